// File: rtl/priority_arb_ctrl_if.sv
// Request/grant bundle between requesters and the shared-resource arbiter.
// The arbiter sits on the slave side.
interface priority_arb_ctrl_if;
    logic [3:0] req;
    logic       mode;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    modport master (
        output req,
        output mode,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid,
        input  timeout
    );

    modport slave (
        input  req,
        input  mode,
        output gnt,
        output gnt_idx,
        output gnt_valid,
        output timeout
    );
endinterface

// File: rtl/priority_arb_ctrl.sv
// Four-way arbiter with fixed-priority or round-robin selection,
// bounded hold time and a mandatory one-cycle gap between grants.
module priority_arb_ctrl #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input logic                clk,
    input logic                rst_n,
    priority_arb_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);

    state_t           state;
    logic [CNT_W-1:0] hold_cnt;
    logic [1:0]       rr_last;
    logic [3:0]       gnt_q;
    logic [1:0]       idx_q;
    logic             valid_q;
    logic             timeout_q;

    logic [1:0] fixed_w;
    logic [1:0] rr_w;
    logic       rr_found;
    logic [1:0] rr_probe;
    logic [1:0] win;
    logic       cur_req;

    // Later iterations override, so the highest set index wins.
    always_comb begin
        fixed_w = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (bus.req[i]) begin
                fixed_w = 2'(i);
            end
        end
    end

    // Scan starts one past the last released index; k=4 wraps to rr_last.
    always_comb begin
        rr_w     = 2'd0;
        rr_found = 1'b0;
        rr_probe = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            rr_probe = rr_last + 2'(k);
            if (!rr_found && bus.req[rr_probe]) begin
                rr_w     = rr_probe;
                rr_found = 1'b1;
            end
        end
    end

    assign win     = bus.mode ? rr_w : fixed_w;
    assign cur_req = bus.req[idx_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            rr_last   <= 2'd3;
            gnt_q     <= 4'd0;
            idx_q     <= 2'd0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE, GAP: begin
                    timeout_q <= 1'b0;
                    if (|bus.req) begin
                        gnt_q    <= 4'b0001 << win;
                        idx_q    <= win;
                        valid_q  <= 1'b1;
                        hold_cnt <= CNT_W'(1);
                        state    <= GRANT;
                    end else begin
                        gnt_q   <= 4'd0;
                        valid_q <= 1'b0;
                        state   <= IDLE;
                    end
                end
                GRANT: begin
                    if (!cur_req) begin
                        gnt_q     <= 4'd0;
                        valid_q   <= 1'b0;
                        rr_last   <= idx_q;
                        timeout_q <= 1'b0;
                        state     <= GAP;
                    end else if (hold_cnt == HOLD_LIMIT) begin
                        gnt_q     <= 4'd0;
                        valid_q   <= 1'b0;
                        rr_last   <= idx_q;
                        timeout_q <= 1'b1;
                        state     <= GAP;
                    end else begin
                        hold_cnt  <= hold_cnt + CNT_W'(1);
                        timeout_q <= 1'b0;
                    end
                end
                default: begin
                    gnt_q     <= 4'd0;
                    valid_q   <= 1'b0;
                    timeout_q <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = idx_q;
    assign bus.gnt_valid = valid_q;
    assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_priority_arb_ctrl.sv
// Scoreboard bench: stimulus queues per-edge expectations,
// a monitor pops and compares after each edge or reset drop.
module tb_priority_arb_ctrl;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       to;
        string      nm;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    priority_arb_ctrl_if bus ();

    priority_arb_ctrl #(
        .MAX_HOLD(4),
        .CNT_W   (8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input string fld,
                       input logic [3:0] act, input logic [3:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s.%s: got %h want %h at %0t",
                     nm, fld, act, want, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk or negedge rst_n);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(e.nm, "gnt", bus.gnt, e.gnt);
                chk(e.nm, "idx", {2'b00, bus.gnt_idx}, {2'b00, e.idx});
                chk(e.nm, "valid", {3'b000, bus.gnt_valid},
                    {3'b000, (e.gnt != 4'd0)});
                chk(e.nm, "timeout", {3'b000, bus.timeout},
                    {3'b000, e.to});
            end
        end
    end

    task automatic push(input logic [3:0] g, input logic [1:0] gi,
                        input logic to, input string nm);
        exp_t e;
        e.gnt = g;
        e.idx = gi;
        e.to  = to;
        e.nm  = nm;
        exp_q.push_back(e);
    endtask

    // Inputs applied here are sampled at the next edge; expectation is for after it.
    task automatic cyc(input logic r, input logic [3:0] rq, input logic md,
                       input logic [3:0] g, input logic [1:0] gi,
                       input logic to, input string nm);
        rst_n    = r;
        bus.req  = rq;
        bus.mode = md;
        push(g, gi, to, nm);
        @(posedge clk);
        #2;
    endtask

    task automatic async_rst(input string nm);
        push(4'd0, 2'd0, 1'b0, nm);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [1:0] slot;
        bus.req  = 4'hF;
        bus.mode = 1'b0;
        @(posedge clk);
        #2;

        repeat (3) cyc(0, 4'hF, 0, 4'd0, 2'd0, 0, "rst");

        cyc(1, 4'b1010, 0, 4'b1000, 2'd3, 0, "fixed");
        cyc(1, 4'b0000, 0, 4'd0, 2'd3, 0, "fixed_rel");
        cyc(1, 4'b0000, 0, 4'd0, 2'd3, 0, "fixed_idle");

        repeat (3) cyc(1, 4'b0100, 0, 4'b0100, 2'd2, 0, "vol");
        cyc(1, 4'b0000, 0, 4'd0, 2'd2, 0, "vol_rel");
        cyc(1, 4'b0000, 0, 4'd0, 2'd2, 0, "vol_idle");

        for (int c = 0; c < 11; c++) begin
            if (c % 5 == 4)
                cyc(1, 4'b0001, 0, 4'd0, 2'd0, 1, "to_rev");
            else
                cyc(1, 4'b0001, 0, 4'b0001, 2'd0, 0, "to_hold");
        end
        cyc(1, 4'b0000, 0, 4'd0, 2'd0, 0, "to_rel");
        cyc(1, 4'b0000, 0, 4'd0, 2'd0, 0, "to_idle");

        cyc(1, 4'hF, 0, 4'b1000, 2'd3, 0, "pre_rst");
        async_rst("async_rst");
        repeat (2) cyc(0, 4'hF, 0, 4'd0, 2'd0, 0, "in_rst");

        for (int c = 0; c < 21; c++) begin
            slot = 2'((c / 5) % 4);
            if (c % 5 == 4)
                cyc(1, 4'hF, 1, 4'd0, slot, 1, "rr_rev");
            else
                cyc(1, 4'hF, 1, 4'b0001 << slot, slot, 0, "rr_hold");
        end
        cyc(1, 4'b0000, 1, 4'd0, 2'd0, 0, "rr_rel");
        cyc(1, 4'b0000, 1, 4'd0, 2'd0, 0, "rr_idle");

        cyc(1, 4'b0010, 1, 4'b0010, 2'd1, 0, "sim_g1");
        repeat (2) cyc(1, 4'b1010, 0, 4'b0010, 2'd1, 0, "sim_nopre");
        cyc(1, 4'b1100, 0, 4'd0, 2'd1, 0, "sim_rel");
        cyc(1, 4'b1100, 0, 4'b1000, 2'd3, 0, "sim_fixed");
        cyc(1, 4'b0000, 0, 4'd0, 2'd3, 0, "sim_end");

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        #3;
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
